// File: rtl/signed_mult16_pkg.sv
// Shared definitions for the signed 16x16 Booth multiplier.
//   WIDTH         operand width
//   PROD_W        full-precision product width
//   booth_digit_t radix-4 Booth digit
//   booth_decode  maps a 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]} to its digit
package signed_mult16_pkg;

  localparam int WIDTH  = 16;
  localparam int PROD_W = 2 * WIDTH;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_t;

  function automatic booth_digit_t booth_decode(input logic [2:0] win);
    booth_digit_t dig;
    dig = ZERO;
    case (win)
      3'b001, 3'b010: dig = POS1;
      3'b011:         dig = POS2;
      3'b100:         dig = NEG2;
      3'b101, 3'b110: dig = NEG1;
      default:        dig = ZERO;  // 000 and 111
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/signed_mult16_booth_pp_gen.sv
// One radix-4 Booth partial-product row.
//   mcand_i  multiplicand, two's complement
//   win_i    3-bit multiplier window
//   pp_o     selected multiple (0, +-m, +-2m) as a signed WIDTH+1-bit value;
//            negative digits are emitted one's-complemented
//   neg_o    +1 that completes the two's-complement negation, added by the caller
module booth_pp_gen
  import signed_mult16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [2:0]       win_i,
  output logic [WIDTH:0]   pp_o,
  output logic             neg_o
);

  booth_digit_t   dig;
  logic [WIDTH:0] m1;
  logic [WIDTH:0] m2;

  assign dig = booth_decode(win_i);
  assign m1  = {mcand_i[WIDTH-1], mcand_i};
  assign m2  = {mcand_i, 1'b0};

  always_comb begin
    pp_o  = '0;
    neg_o = 1'b0;
    case (dig)
      POS1: pp_o = m1;
      POS2: pp_o = m2;
      NEG1: begin
        pp_o  = ~m1;
        neg_o = 1'b1;
      end
      NEG2: begin
        pp_o  = ~m2;
        neg_o = 1'b1;
      end
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/signed_mult16.sv
// Pipelined two's-complement multiplier, 2-cycle latency, one result per clock.
//   clk               system clock
//   rst               asynchronous active-high reset
//   in_valid          qualifies in0/in1
//   in0, in1          multiplicand / multiplier
//   out_valid         final_signedprod carries a new result
//   final_signedprod  full-precision signed product, held while out_valid is low
module signed_mult16
  import signed_mult16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] final_signedprod
);

  localparam int PW   = 2 * WIDTH;
  localparam int NDIG = WIDTH / 2;

  function automatic logic [PW-1:0] csa_sum(input logic [PW-1:0] a, b, c);
    return a ^ b ^ c;
  endfunction

  function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] a, b, c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  // Multiplier with the implicit zero below bit 0 for the first window.
  logic [WIDTH:0]  mplier_ext;
  logic [WIDTH:0]  pp [NDIG];
  logic [NDIG-1:0] neg;

  assign mplier_ext = {in1, 1'b0};

  for (genvar i = 0; i < NDIG; i++) begin : g_pp
    booth_pp_gen #(.WIDTH(WIDTH)) u_pp (
      .mcand_i (in0),
      .win_i   (mplier_ext[2*i+2 -: 3]),
      .pp_o    (pp[i]),
      .neg_o   (neg[i])
    );
  end

  // Rows 0..NDIG-1 are the shifted, sign-extended partial products; the last
  // row gathers the negation carry-ins, which never collide since each sits
  // at its own even bit position.
  logic [PW-1:0] row [NDIG+1];

  always_comb begin
    for (int i = 0; i <= NDIG; i++) row[i] = '0;
    for (int i = 0; i < NDIG; i++) begin
      row[i]          = PW'($signed(pp[i])) << (2 * i);
      row[NDIG][2*i]  = neg[i];
    end
  end

  // 9 rows -> 6 -> 4 -> 3 -> 2 with 3:2 compressors.
  logic [PW-1:0] s1a, c1a, s1b, c1b, s1c, c1c;
  logic [PW-1:0] s2a, c2a, s2b, c2b;
  logic [PW-1:0] s3, c3;
  logic [PW-1:0] sum_d, carry_d;

  assign s1a = csa_sum  (row[0], row[1], row[2]);
  assign c1a = csa_carry(row[0], row[1], row[2]);
  assign s1b = csa_sum  (row[3], row[4], row[5]);
  assign c1b = csa_carry(row[3], row[4], row[5]);
  assign s1c = csa_sum  (row[6], row[7], row[8]);
  assign c1c = csa_carry(row[6], row[7], row[8]);

  assign s2a = csa_sum  (s1a, c1a, s1b);
  assign c2a = csa_carry(s1a, c1a, s1b);
  assign s2b = csa_sum  (c1b, s1c, c1c);
  assign c2b = csa_carry(c1b, s1c, c1c);

  assign s3  = csa_sum  (s2a, c2a, s2b);
  assign c3  = csa_carry(s2a, c2a, s2b);

  assign sum_d   = csa_sum  (s3, c3, c2b);
  assign carry_d = csa_carry(s3, c3, c2b);

  logic [PW-1:0] sum_q, carry_q, prod_q, prod_d;
  logic          v1_q, out_valid_q;

  assign prod_d = sum_q + carry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      carry_q     <= '0;
      v1_q        <= 1'b0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      v1_q        <= in_valid;
      out_valid_q <= v1_q;
      if (v1_q) prod_q <= prod_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign final_signedprod = prod_q;

endmodule

// File: tb/tb_signed_mult16.sv
module tb_signed_mult16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in0;
  logic [15:0] in1;
  logic        out_valid;
  logic [31:0] final_signedprod;

  signed_mult16 dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in0              (in0),
    .in1              (in1),
    .out_valid        (out_valid),
    .final_signedprod (final_signedprod)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          edge_n;
    logic [31:0] p;
  } exp_t;

  exp_t        q[$];
  logic [31:0] last_p;
  bit          mon_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    return 32'(sa * sb);
  endfunction

  // Operands driven just after edge c must appear after edge c+2; otherwise
  // out_valid is low and the last product is held.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].edge_n + 2 == cyc) begin
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("product", final_signedprod, q[0].p);
        last_p = q[0].p;
        void'(q.pop_front());
      end else begin
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("hold", final_signedprod, last_p);
      end
    end
  end

  task automatic issue(input bit v, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp);
    exp_t e;
    @(negedge clk);
    #2;
    in_valid = v;
    in0      = a;
    in1      = b;
    if (v) begin
      e.edge_n = cyc;
      e.p      = exp;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 16'($urandom), 16'($urandom), 32'd0);
  endtask

  logic [15:0] da [9] = '{16'd0, 16'd1234, 16'd0, 16'hFFFF, 16'hFB2E,
                          16'd30000, 16'h8000, 16'h7FFF, 16'h7FFF};
  logic [15:0] db [9] = '{16'd0, 16'd0, 16'hE9D2, 16'hFFFF, 16'd54,
                          16'd30000, 16'h8000, 16'h8000, 16'h7FFF};
  logic [31:0] dp [9] = '{32'h0, 32'h0, 32'h0, 32'h00000001, 32'hFFFEFBB4,
                          32'h35A4E900, 32'h40000000, 32'hC0008000, 32'h3FFF0001};
  logic [15:0] corners [6] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h8001};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b;
    bit          v;

    rst      = 1'b1;
    in_valid = 1'b0;
    in0      = '0;
    in1      = '0;
    mon_en   = 1'b0;
    last_p   = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_prod", final_signedprod, 32'd0);
    #2;
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Directed vectors, each isolated.
    for (int i = 0; i < 9; i++) begin
      issue(1'b1, da[i], db[i], dp[i]);
      idle(3);
    end

    // Five back-to-back, then idle: results in order, then held.
    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      issue(1'b1, a, b, ref_mul(a, b));
    end
    idle(4);

    // Random traffic with gaps and occasional corner operands.
    for (int i = 0; i < 1000; i++) begin
      v = ($urandom_range(3) != 0);
      a = ($urandom_range(7) == 0) ? corners[$urandom_range(5)] : 16'($urandom);
      b = ($urandom_range(7) == 0) ? corners[$urandom_range(5)] : 16'($urandom);
      issue(v, a, b, ref_mul(a, b));
    end
    idle(4);

    // Leave a nonzero held product, then reset with two operands in flight.
    issue(1'b1, 16'd30000, 16'd30000, 32'h35A4E900);
    idle(3);
    mon_en = 1'b0;
    @(negedge clk);
    #2;
    in_valid = 1'b1;
    in0      = 16'd1234;
    in1      = 16'd5678;
    @(negedge clk);
    #2;
    in0 = 16'h8000;
    in1 = 16'h8000;
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_prod", final_signedprod, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    q.delete();
    last_p = '0;
    mon_en = 1'b1;
    idle(4);
    a = 16'hFB2E;
    b = 16'd54;
    issue(1'b1, a, b, ref_mul(a, b));
    idle(4);

    chk("drain", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/signed_mult16.md
Name:
signed_mult16

Overview:
- Pipelined 16x16 two's-complement multiplier producing a full-precision 32-bit signed product.
- Sits in the arithmetic unit of the 16-bit ALU, alongside add/sub, and feeds the result mux.
- Uses radix-4 Booth partial-product generation and a registered reduction, giving a fixed 2-cycle latency and one result per clock.

Parameters:
- WIDTH, 16, operand width in bits. The product width is 2*WIDTH. Only 16 is verified.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies in0/in1 for capture this cycle.
- in0  input  16  multiplicand, two's complement.
- in1  input  16  multiplier, two's complement.
- out_valid  output  1  final_signedprod holds a new result this cycle.
- final_signedprod  output  32  signed product in0*in1, two's complement.

Behaviour:
- Reset (async, active-high): out_valid=0, final_signedprod=0, all pipeline registers and stage-valid bits cleared. Reset asserted mid-operation discards every in-flight operand, and no out_valid pulse follows.
- Arithmetic:
  - final_signedprod = sign-extended(in0) * sign-extended(in1), exact over 32 bits. No overflow is possible.
  - -32768 * -32768 = +2^30 (0x40000000), which is the extreme case.
  - The product of any operand with 0 is 0.
- Stage 1 (edge after capture):
  - in1 is Booth-recoded radix-4 into 8 digits in {-2,-1,0,+1,+2}, with an implicit 0 appended below bit 0.
  - Each digit selects 0, ±in0, or ±2*in0, sign-extended to 32 bits and shifted by 2*i.
  - Negation uses invert plus a carry-in bit, folded into the sum.
  - The partial products are reduced to a carry-save pair (sum, carry), and that pair is registered along with v1=in_valid.
- Stage 2 (next edge): final_signedprod <= sum + carry (mod 2^32), out_valid <= v1.
- Latency: operands sampled on edge N give a result visible after edge N+2. Throughput is 1 per cycle with no stalls and no backpressure.
- When in_valid=0 the pipeline still advances. out_valid deasserts 2 cycles later, and final_signedprod holds its last valid value (no update when the stage valid is 0).
- Back-to-back valid inputs produce back-to-back results in order.
- Outputs are purely registered, with no combinational input-to-output path.

Decomposition:
- A shared package holds:
  - localparam WIDTH=16 and PROD_W=32;
  - a Booth digit typedef (enum: ZERO, POS1, POS2, NEG1, NEG2);
  - a function booth_decode(3-bit window) that returns the digit.
- One sub-module, booth_pp_gen: inputs are the multiplicand and a 3-bit window; outputs are a 17-bit partial product plus a negate bit. It is instantiated 8 times.
- The carry-save reduction (3:2 compressor tree) stays inline in signed_mult16.

Test Plan:
- Zeros: (0,0), (1234,0), (0,-5678) each with in_valid=1 -> out_valid after 2 cycles, product 0x00000000.
- Sign handling: (-1,-1) -> 0x00000001; (-1234,54) -> 0xFFFEFBB4 (-66636).
- Large positive: (30000,30000) -> 0x35A4E900 (900000000).
- Extremes: (0x8000,0x8000) -> 0x40000000; (0x7FFF,0x8000) -> 0xC0008000; (0x7FFF,0x7FFF) -> 0x3FFF0001.
- Streaming: 5 back-to-back valid pairs, then in_valid low -> 5 consecutive out_valid results in order, then out_valid=0 with the last product held; 1000 random pairs checked against a $signed reference model.
- Reset mid-flight: assert rst while two operands are in the pipeline -> out_valid=0 and product=0 immediately (asynchronously), no stale result after release, and the first post-reset input yields its correct product 2 cycles later.
